// File: rtl/dcache_dma_if.sv
// Command port, status flags and single-port cache bus of the block-transfer initiator.
// The master modport is the initiator; the slave modport is the control path plus cache.
interface dcache_dma_if #(
    parameter int WORD_COUNT = 64,
    parameter int WORD_BITS  = 32
);
    localparam int BYTES_PER_WORD = WORD_BITS / 8;
    localparam int ADDR_BITS      = $clog2(WORD_COUNT * BYTES_PER_WORD);
    localparam int LEN_BITS       = $clog2(WORD_COUNT) + 1;

    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic                 cmd_mode_i;
    logic [ADDR_BITS-1:0] cmd_src_i;
    logic [ADDR_BITS-1:0] cmd_dst_i;
    logic [LEN_BITS-1:0]  cmd_len_i;
    logic [WORD_BITS-1:0] cmd_fill_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [ADDR_BITS-1:0] address_o;
    logic [WORD_BITS-1:0] rd_data_i;
    logic [WORD_BITS-1:0] wr_data_o;
    logic                 wr_en_o;

    modport master (
        input  cmd_valid_i, cmd_mode_i, cmd_src_i, cmd_dst_i, cmd_len_i, cmd_fill_i, rd_data_i,
        output cmd_ready_o, busy_o, done_o, err_o, address_o, wr_data_o, wr_en_o
    );

    modport slave (
        output cmd_valid_i, cmd_mode_i, cmd_src_i, cmd_dst_i, cmd_len_i, cmd_fill_i, rd_data_i,
        input  cmd_ready_o, busy_o, done_o, err_o, address_o, wr_data_o, wr_en_o
    );
endinterface

// File: rtl/dcache_dma.sv
// Block-transfer initiator for the single-port data cache: word copy (read/write per word)
// and constant fill (one write per word), one command at a time, all outputs registered.
module dcache_dma #(
    parameter int WORD_COUNT = 64,
    parameter int WORD_BITS  = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    dcache_dma_if.master  bus
);
    localparam int BYTES_PER_WORD = WORD_BITS / 8;
    localparam int ADDR_BITS      = $clog2(WORD_COUNT * BYTES_PER_WORD);
    localparam int LEN_BITS       = $clog2(WORD_COUNT) + 1;
    localparam int RANGE_BITS     = ADDR_BITS + 2;

    localparam logic [RANGE_BITS-1:0] MEM_BYTES  = RANGE_BITS'(WORD_COUNT * BYTES_PER_WORD);
    localparam logic [RANGE_BITS-1:0] STEP_WIDE  = RANGE_BITS'(BYTES_PER_WORD);
    localparam logic [ADDR_BITS-1:0]  STEP       = ADDR_BITS'(BYTES_PER_WORD);
    localparam logic [ADDR_BITS-1:0]  ALIGN_MASK = ADDR_BITS'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Span end is formed two bits wider than an address so base + len*step never wraps.
    function automatic logic out_of_range(input logic [ADDR_BITS-1:0] base,
                                          input logic [LEN_BITS-1:0]  len);
        logic [RANGE_BITS-1:0] span_end;
        span_end = RANGE_BITS'(base) + (RANGE_BITS'(len) * STEP_WIDE);
        return (span_end > MEM_BYTES);
    endfunction

    function automatic logic misaligned(input logic [ADDR_BITS-1:0] addr);
        return ((addr & ALIGN_MASK) != {ADDR_BITS{1'b0}});
    endfunction

    state_t               state_r, nxt_state_s;
    logic                 mode_r, nxt_mode_s;
    logic [ADDR_BITS-1:0] src_r, nxt_src_s;
    logic [ADDR_BITS-1:0] dst_r, nxt_dst_s;
    logic [LEN_BITS-1:0]  remain_r, nxt_remain_s;
    logic [WORD_BITS-1:0] fill_r, nxt_fill_s;
    logic [WORD_BITS-1:0] buf_r, nxt_buf_s;
    logic                 err_r, nxt_err_s;
    logic                 cmd_err_s;

    logic                 cmd_ready_r, nxt_cmd_ready_s;
    logic                 busy_r, nxt_busy_s;
    logic                 done_r, nxt_done_s;
    logic                 err_out_r, nxt_err_out_s;
    logic [ADDR_BITS-1:0] address_r, nxt_address_s;
    logic [WORD_BITS-1:0] wr_data_r, nxt_wr_data_s;
    logic                 wr_en_r, nxt_wr_en_s;

    // Command legality: alignment and range of destination, and of source for copies.
    always_comb begin
        cmd_err_s = misaligned(bus.cmd_dst_i) | out_of_range(bus.cmd_dst_i, bus.cmd_len_i);
        if (bus.cmd_mode_i == 1'b0) begin
            cmd_err_s = cmd_err_s | misaligned(bus.cmd_src_i)
                                  | out_of_range(bus.cmd_src_i, bus.cmd_len_i);
        end else begin
            cmd_err_s = cmd_err_s;
        end
    end

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_mode_s   = mode_r;
        nxt_src_s    = src_r;
        nxt_dst_s    = dst_r;
        nxt_remain_s = remain_r;
        nxt_fill_s   = fill_r;
        nxt_buf_s    = buf_r;
        nxt_err_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    nxt_mode_s   = bus.cmd_mode_i;
                    nxt_src_s    = bus.cmd_src_i;
                    nxt_dst_s    = bus.cmd_dst_i;
                    nxt_remain_s = bus.cmd_len_i;
                    nxt_fill_s   = bus.cmd_fill_i;
                    nxt_err_s    = cmd_err_s;
                    if (cmd_err_s || (bus.cmd_len_i == {LEN_BITS{1'b0}})) begin
                        nxt_state_s = ST_DONE;
                    end else if (bus.cmd_mode_i) begin
                        nxt_state_s = ST_WRITE;
                    end else begin
                        nxt_state_s = ST_READ;
                    end
                end else begin
                    nxt_err_s = 1'b0;
                end
            end
            ST_READ: begin
                nxt_buf_s   = bus.rd_data_i;
                nxt_state_s = ST_WRITE;
            end
            ST_WRITE: begin
                nxt_src_s    = src_r + STEP;
                nxt_dst_s    = dst_r + STEP;
                nxt_remain_s = remain_r - LEN_BITS'(1);
                if (remain_r == LEN_BITS'(1)) begin
                    nxt_state_s = ST_DONE;
                end else if (mode_r) begin
                    nxt_state_s = ST_WRITE;
                end else begin
                    nxt_state_s = ST_READ;
                end
            end
            ST_DONE: begin
                nxt_state_s = ST_IDLE;
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from the upcoming state so they leave the block registered.
    always_comb begin
        nxt_cmd_ready_s = 1'b0;
        nxt_busy_s      = 1'b0;
        nxt_done_s      = 1'b0;
        nxt_err_out_s   = 1'b0;
        nxt_address_s   = {ADDR_BITS{1'b0}};
        nxt_wr_data_s   = {WORD_BITS{1'b0}};
        nxt_wr_en_s     = 1'b0;
        case (nxt_state_s)
            ST_IDLE: begin
                nxt_cmd_ready_s = 1'b1;
            end
            ST_READ: begin
                nxt_busy_s    = 1'b1;
                nxt_address_s = nxt_src_s;
            end
            ST_WRITE: begin
                nxt_busy_s    = 1'b1;
                nxt_address_s = nxt_dst_s;
                nxt_wr_en_s   = 1'b1;
                nxt_wr_data_s = nxt_mode_s ? nxt_fill_s : nxt_buf_s;
            end
            ST_DONE: begin
                nxt_busy_s    = 1'b1;
                nxt_done_s    = 1'b1;
                nxt_err_out_s = nxt_err_s;
            end
            default: begin
                nxt_cmd_ready_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything except the ready flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            src_r       <= {ADDR_BITS{1'b0}};
            dst_r       <= {ADDR_BITS{1'b0}};
            remain_r    <= {LEN_BITS{1'b0}};
            fill_r      <= {WORD_BITS{1'b0}};
            buf_r       <= {WORD_BITS{1'b0}};
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_out_r   <= 1'b0;
            address_r   <= {ADDR_BITS{1'b0}};
            wr_data_r   <= {WORD_BITS{1'b0}};
            wr_en_r     <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            mode_r      <= nxt_mode_s;
            src_r       <= nxt_src_s;
            dst_r       <= nxt_dst_s;
            remain_r    <= nxt_remain_s;
            fill_r      <= nxt_fill_s;
            buf_r       <= nxt_buf_s;
            err_r       <= nxt_err_s;
            cmd_ready_r <= nxt_cmd_ready_s;
            busy_r      <= nxt_busy_s;
            done_r      <= nxt_done_s;
            err_out_r   <= nxt_err_out_s;
            address_r   <= nxt_address_s;
            wr_data_r   <= nxt_wr_data_s;
            wr_en_r     <= nxt_wr_en_s;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_r;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.err_o       = err_out_r;
    assign bus.address_o   = address_r;
    assign bus.wr_data_o   = wr_data_r;
    assign bus.wr_en_o     = wr_en_r;
endmodule
